// File: rtl/vram_cam_pkg.sv
// Shared FSM encoding and default capture window for the camera-to-VRAM packer.
package vram_cam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitVs,
        StCapture,
        StFlush,
        StDone
    } cap_state_e;

    localparam int unsigned DefPixW     = 12;
    localparam int unsigned DefWordW    = 32;
    localparam int unsigned DefAddrW    = 13;
    localparam int unsigned DefHStart   = 256;
    localparam int unsigned DefVStart   = 128;
    localparam int unsigned DefCapW     = 256;
    localparam int unsigned DefCapH     = 128;
    localparam int unsigned DefDec      = 2;
    localparam int unsigned DefBaseAddr = 0;

endpackage

// File: rtl/pix_packer.sv
// Packs PIX_W-bit pixels LSB-first into WORD_W-bit words; a pixel may straddle two words.
module pix_packer #(
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [PIX_W-1:0]  pix,
    input  logic              pix_vld,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              word_vld
);

    localparam int unsigned AccW  = 2 * WORD_W;
    localparam int unsigned FillW = $clog2(AccW) + 1;

    logic [AccW-1:0]   acc_q, acc_d, acc_add;
    logic [FillW-1:0]  fill_q, fill_d, fill_add;
    logic [WORD_W-1:0] word_q, word_d;
    logic              vld_q, vld_d;

    always_comb begin
        acc_add  = acc_q | (AccW'(pix) << fill_q);
        fill_add = fill_q + FillW'(PIX_W);
        acc_d    = acc_q;
        fill_d   = fill_q;
        word_d   = word_q;
        vld_d    = 1'b0;
        if (clr) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (flush) begin
            // Bits above the fill count are always zero, so the pad comes for free.
            if (fill_q != '0) begin
                word_d = acc_q[WORD_W-1:0];
                vld_d  = 1'b1;
            end
            acc_d  = '0;
            fill_d = '0;
        end else if (pix_vld) begin
            if (fill_add >= FillW'(WORD_W)) begin
                word_d = acc_add[WORD_W-1:0];
                vld_d  = 1'b1;
                acc_d  = acc_add >> WORD_W;
                fill_d = fill_add - FillW'(WORD_W);
            end else begin
                acc_d  = acc_add;
                fill_d = fill_add;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign word     = word_q;
    assign word_vld = vld_q;

endmodule

// File: rtl/vram_pack_wr.sv
// Captures a decimated window of a byte-serial camera stream and writes packed pixels to VRAM.
module vram_pack_wr
    import vram_cam_pkg::*;
#(
    parameter int unsigned PIX_W     = DefPixW,
    parameter int unsigned WORD_W    = DefWordW,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned H_START   = DefHStart,
    parameter int unsigned V_START   = DefVStart,
    parameter int unsigned CAP_W     = DefCapW,
    parameter int unsigned CAP_H     = DefCapH,
    parameter int unsigned DEC       = DefDec,
    parameter int unsigned BASE_ADDR = DefBaseAddr
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_valid,
    input  logic [7:0]        cam_data,
    input  logic              arm,
    input  logic              cont,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [WORD_W-1:0] dina,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_short,
    output logic [ADDR_W-1:0] word_cnt
);

    localparam logic [15:0]       XLo     = 16'(H_START);
    localparam logic [15:0]       XHi     = 16'(H_START + CAP_W);
    localparam logic [15:0]       YLo     = 16'(V_START);
    localparam logic [15:0]       YHi     = 16'(V_START + CAP_H);
    localparam logic [15:0]       DecMask = 16'(DEC - 1);
    localparam logic [ADDR_W-1:0] Base    = ADDR_W'(BASE_ADDR);

    cap_state_e        state_q, state_d;
    logic              vs_q, vs_qq, hr_q, hr_qq;
    logic              vs_rise, hr_rise, hr_fall;
    logic [15:0]       x_q, x_d, y_q, y_d, xo, yo;
    logic              phase_q, phase_d;
    logic [7:0]        first_q, first_d;
    logic [ADDR_W-1:0] addra_q, addra_d, word_cnt_q, word_cnt_d;
    logic              short_q, short_d;
    logic              byte_take, in_win, pix_vld, start, flush;
    logic [PIX_W-1:0]  pix;
    logic [WORD_W-1:0] word;
    logic              word_vld;

    always_comb begin
        vs_rise   = vs_q & ~vs_qq;
        hr_rise   = hr_q & ~hr_qq;
        hr_fall   = ~hr_q & hr_qq;
        // Line/frame edges win over a coincident byte.
        byte_take = (state_q == StCapture) && cam_href && cam_valid
                    && !vs_rise && !hr_rise && !hr_fall;
        pix       = PIX_W'({first_q, cam_data});
        xo        = x_q - XLo;
        yo        = y_q - YLo;
        in_win    = (x_q >= XLo) && (x_q < XHi) && (y_q >= YLo) && (y_q < YHi)
                    && ((xo & DecMask) == '0) && ((yo & DecMask) == '0);
        pix_vld   = byte_take && phase_q && in_win;

        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        phase_d    = phase_q;
        first_d    = first_q;
        addra_d    = addra_q;
        word_cnt_d = word_cnt_q;
        short_d    = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;

        if (word_vld) begin
            addra_d = addra_q + ADDR_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (arm || cont) state_d = StWaitVs;
            end
            StWaitVs: begin
                if (vs_rise) begin
                    state_d = StCapture;
                    start   = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    first_d = '0;
                    addra_d = Base;
                end
            end
            StCapture: begin
                if (vs_rise) begin
                    state_d = StFlush;
                    short_d = 1'b1;
                end else if (hr_fall) begin
                    y_d = y_q + 16'd1;
                    x_d = '0;
                    if (y_q + 16'd1 == YHi) state_d = StFlush;
                end else if (hr_rise) begin
                    phase_d = 1'b0;
                end else if (byte_take) begin
                    phase_d = ~phase_q;
                    if (!phase_q) first_d = cam_data;
                    else          x_d     = x_q + 16'd1;
                end
            end
            StFlush: begin
                flush   = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                // The flush word, if any, is on the port this cycle and not yet counted.
                word_cnt_d = addra_q - Base + ADDR_W'(word_vld);
                state_d    = cont ? StWaitVs : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            vs_q       <= 1'b0;
            vs_qq      <= 1'b0;
            hr_q       <= 1'b0;
            hr_qq      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            phase_q    <= 1'b0;
            first_q    <= '0;
            addra_q    <= Base;
            word_cnt_q <= '0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= cam_vsync;
            vs_qq      <= vs_q;
            hr_q       <= cam_href;
            hr_qq      <= hr_q;
            x_q        <= x_d;
            y_q        <= y_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            addra_q    <= addra_d;
            word_cnt_q <= word_cnt_d;
            short_q    <= short_d;
        end
    end

    pix_packer #(
        .PIX_W  (PIX_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .pix      (pix),
        .pix_vld  (pix_vld),
        .flush    (flush),
        .word     (word),
        .word_vld (word_vld)
    );

    assign wea         = word_vld;
    assign dina        = word;
    assign addra       = addra_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = (state_q == StDone);
    assign frame_short = short_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_vram_pack_wr.sv
// Directed bench: four packer instances with small windows share one camera stream.
module tb_vram_pack_wr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       cam_vsync = 1'b0, cam_href = 1'b0, cam_valid = 1'b0;
    logic [7:0] cam_data = 8'h00;

    logic        rst_v [4];
    logic        arm_v [4];
    logic        cont_v[4];
    logic        wea_v [4];
    logic [12:0] addra_v[4];
    logic [31:0] dina_v[4];
    logic        busy_v[4];
    logic        fd_v  [4];
    logic        fs_v  [4];
    logic [12:0] wc_v  [4];

    logic [12:0] wr_addr[4][64];
    logic [31:0] wr_data[4][64];
    int          wr_n[4], done_n[4], short_n[4];

    logic [31:0] exp_w[64];
    int          exp_n;
    int          vec_n = 0;
    int          miss_n = 0;

    vram_pack_wr #(.PIX_W(12), .WORD_W(32), .ADDR_W(13), .H_START(2), .V_START(1),
                   .CAP_W(8), .CAP_H(1), .DEC(1), .BASE_ADDR(0)) u_a (
        .clk(clk), .rst(rst_v[0]), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_valid(cam_valid), .cam_data(cam_data), .arm(arm_v[0]), .cont(cont_v[0]),
        .wea(wea_v[0]), .addra(addra_v[0]), .dina(dina_v[0]), .busy(busy_v[0]),
        .frame_done(fd_v[0]), .frame_short(fs_v[0]), .word_cnt(wc_v[0]));

    vram_pack_wr #(.PIX_W(12), .WORD_W(32), .ADDR_W(13), .H_START(2), .V_START(1),
                   .CAP_W(6), .CAP_H(1), .DEC(1), .BASE_ADDR(0)) u_b (
        .clk(clk), .rst(rst_v[1]), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_valid(cam_valid), .cam_data(cam_data), .arm(arm_v[1]), .cont(cont_v[1]),
        .wea(wea_v[1]), .addra(addra_v[1]), .dina(dina_v[1]), .busy(busy_v[1]),
        .frame_done(fd_v[1]), .frame_short(fs_v[1]), .word_cnt(wc_v[1]));

    vram_pack_wr #(.PIX_W(12), .WORD_W(32), .ADDR_W(13), .H_START(2), .V_START(1),
                   .CAP_W(16), .CAP_H(4), .DEC(2), .BASE_ADDR(13'h100)) u_c (
        .clk(clk), .rst(rst_v[2]), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_valid(cam_valid), .cam_data(cam_data), .arm(arm_v[2]), .cont(cont_v[2]),
        .wea(wea_v[2]), .addra(addra_v[2]), .dina(dina_v[2]), .busy(busy_v[2]),
        .frame_done(fd_v[2]), .frame_short(fs_v[2]), .word_cnt(wc_v[2]));

    vram_pack_wr #(.PIX_W(12), .WORD_W(32), .ADDR_W(13), .H_START(2), .V_START(1),
                   .CAP_W(6), .CAP_H(4), .DEC(1), .BASE_ADDR(0)) u_d (
        .clk(clk), .rst(rst_v[3]), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_valid(cam_valid), .cam_data(cam_data), .arm(arm_v[3]), .cont(cont_v[3]),
        .wea(wea_v[3]), .addra(addra_v[3]), .dina(dina_v[3]), .busy(busy_v[3]),
        .frame_done(fd_v[3]), .frame_short(fs_v[3]), .word_cnt(wc_v[3]));

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wea_v[k] === 1'b1) begin
                if (wr_n[k] < 64) begin
                    wr_addr[k][wr_n[k]] = addra_v[k];
                    wr_data[k][wr_n[k]] = dina_v[k];
                end
                wr_n[k]++;
            end
            if (fd_v[k] === 1'b1) done_n[k]++;
            if (fs_v[k] === 1'b1) short_n[k]++;
        end
    end

    function automatic logic [15:0] pixval(int x, int y);
        logic [15:0] r;
        r = {4'hA, 4'(y), 8'(x)};
        return r;
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon(int k);
        wr_n[k] = 0;
        done_n[k] = 0;
        short_n[k] = 0;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        tick(3);
        cam_vsync = 1'b0;
        tick(4);
    endtask

    task automatic send_line(int y, int npx);
        logic [15:0] pv;
        cam_href = 1'b1;
        tick(3);
        for (int x = 0; x < npx; x++) begin
            pv = pixval(x, y);
            cam_valid = 1'b1;
            cam_data = pv[15:8];
            tick(1);
            if (x % 3 == 2) begin
                cam_valid = 1'b0;
                tick(1);
                cam_valid = 1'b1;
            end
            cam_data = pv[7:0];
            tick(1);
        end
        cam_valid = 1'b0;
        tick(3);
        cam_href = 1'b0;
        tick(2);
        // Strobes with href low must be ignored.
        cam_valid = 1'b1;
        cam_data = 8'hFF;
        tick(2);
        cam_valid = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(int nlines, int npx);
        vsync_pulse();
        for (int y = 0; y < nlines; y++) send_line(y, npx);
        tick(5);
    endtask

    // Reference packing: window/decimation selection then a flat LSB-first bit stream.
    task automatic build_exp(int cw, int ch, int dec, int nlines, int npx);
        logic [1023:0] bits;
        logic [15:0]   pv;
        int            nb;
        bits = '0;
        nb = 0;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < npx; x++) begin
                if (x >= 2 && x < 2 + cw && y >= 1 && y < 1 + ch &&
                    (x - 2) % dec == 0 && (y - 1) % dec == 0) begin
                    pv = pixval(x, y);
                    for (int b = 0; b < 12; b++) bits[nb + b] = pv[b];
                    nb += 12;
                end
            end
        end
        exp_n = (nb + 31) / 32;
        for (int w = 0; w < exp_n; w++) exp_w[w] = bits[w*32 +: 32];
    endtask

    task automatic test_reset();
        logic [12:0] base;
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1;
            arm_v[k] = 1'b0;
            cont_v[k] = 1'b0;
        end
        tick(3);
        for (int k = 0; k < 4; k++) begin
            base = (k == 2) ? 13'h100 : 13'h000;
            vec_n++;
            if (wea_v[k] !== 1'b0 || addra_v[k] !== base || dina_v[k] !== 32'h0 ||
                busy_v[k] !== 1'b0 || fd_v[k] !== 1'b0 || fs_v[k] !== 1'b0 ||
                wc_v[k] !== 13'h0) begin
                miss_n++;
                $display("FAIL reset dut%0d: wea=%b addra=%h dina=%h busy=%b fd=%b fs=%b wc=%h, want 0/%h/0/0/0/0/0",
                         k, wea_v[k], addra_v[k], dina_v[k], busy_v[k], fd_v[k], fs_v[k],
                         wc_v[k], base);
            end
        end
        for (int k = 0; k < 4; k++) rst_v[k] = 1'b0;
        tick(2);
    endtask

    task automatic test_pack_exact();
        clear_mon(0);
        arm_v[0] = 1'b1;
        tick(1);
        arm_v[0] = 1'b0;
        tick(1);
        vec_n++;
        if (busy_v[0] !== 1'b1) begin
            miss_n++;
            $display("FAIL exact_busy: got %b want 1", busy_v[0]);
        end
        send_frame(3, 12);
        build_exp(8, 1, 1, 3, 12);
        vec_n++;
        if (wr_n[0] !== 3 || exp_n !== 3) begin
            miss_n++;
            $display("FAIL exact_nwr: got %0d want 3 (model %0d)", wr_n[0], exp_n);
        end
        for (int i = 0; i < 3; i++) begin
            vec_n++;
            if (wr_addr[0][i] !== 13'(i) || wr_data[0][i] !== exp_w[i]) begin
                miss_n++;
                $display("FAIL exact_word%0d: got @%h %h want @%h %h", i, wr_addr[0][i],
                         wr_data[0][i], 13'(i), exp_w[i]);
            end
        end
        vec_n++;
        if (wr_data[0][0][11:0] !== 12'h102 || wr_data[0][0][31:24] !== 8'h04) begin
            miss_n++;
            $display("FAIL exact_straddle: got %h want low 102 top 04", wr_data[0][0]);
        end
        vec_n++;
        if (done_n[0] !== 1 || wc_v[0] !== 13'd3 || busy_v[0] !== 1'b0) begin
            miss_n++;
            $display("FAIL exact_done: got done=%0d wc=%0d busy=%b want 1 3 0",
                     done_n[0], wc_v[0], busy_v[0]);
        end
    endtask

    task automatic test_pack_flush();
        clear_mon(1);
        arm_v[1] = 1'b1;
        tick(1);
        arm_v[1] = 1'b0;
        send_frame(3, 12);
        build_exp(6, 1, 1, 3, 12);
        vec_n++;
        if (wr_n[1] !== 3 || exp_n !== 3) begin
            miss_n++;
            $display("FAIL flush_nwr: got %0d want 3 (model %0d)", wr_n[1], exp_n);
        end
        for (int i = 0; i < 3; i++) begin
            vec_n++;
            if (wr_addr[1][i] !== 13'(i) || wr_data[1][i] !== exp_w[i]) begin
                miss_n++;
                $display("FAIL flush_word%0d: got @%h %h want @%h %h", i, wr_addr[1][i],
                         wr_data[1][i], 13'(i), exp_w[i]);
            end
        end
        vec_n++;
        if (wr_data[1][2] !== 32'h0000_0010) begin
            miss_n++;
            $display("FAIL flush_pad: got %h want 00000010", wr_data[1][2]);
        end
        vec_n++;
        if (done_n[1] !== 1 || wc_v[1] !== 13'd3) begin
            miss_n++;
            $display("FAIL flush_done: got done=%0d wc=%0d want 1 3", done_n[1], wc_v[1]);
        end
    endtask

    task automatic test_decimate();
        clear_mon(2);
        arm_v[2] = 1'b1;
        tick(1);
        arm_v[2] = 1'b0;
        send_frame(6, 20);
        build_exp(16, 4, 2, 6, 20);
        vec_n++;
        if (wr_n[2] !== 6 || exp_n !== 6) begin
            miss_n++;
            $display("FAIL dec_nwr: got %0d want 6 (model %0d)", wr_n[2], exp_n);
        end
        for (int i = 0; i < 6; i++) begin
            vec_n++;
            if (wr_addr[2][i] !== 13'(13'h100 + i) || wr_data[2][i] !== exp_w[i]) begin
                miss_n++;
                $display("FAIL dec_word%0d: got @%h %h want @%h %h", i, wr_addr[2][i],
                         wr_data[2][i], 13'(13'h100 + i), exp_w[i]);
            end
        end
        vec_n++;
        if (wc_v[2] !== 13'd6 || done_n[2] !== 1) begin
            miss_n++;
            $display("FAIL dec_done: got wc=%0d done=%0d want 6 1", wc_v[2], done_n[2]);
        end
    endtask

    task automatic test_short_frame();
        clear_mon(3);
        arm_v[3] = 1'b1;
        tick(1);
        arm_v[3] = 1'b0;
        vsync_pulse();
        for (int y = 0; y < 3; y++) send_line(y, 8);
        vsync_pulse();
        tick(5);
        build_exp(6, 4, 1, 3, 8);
        vec_n++;
        if (short_n[3] !== 1) begin
            miss_n++;
            $display("FAIL short_pulse: got %0d cycles want 1", short_n[3]);
        end
        vec_n++;
        if (wr_n[3] !== 5 || exp_n !== 5) begin
            miss_n++;
            $display("FAIL short_nwr: got %0d want 5 (model %0d)", wr_n[3], exp_n);
        end
        for (int i = 0; i < 5; i++) begin
            vec_n++;
            if (wr_addr[3][i] !== 13'(i) || wr_data[3][i] !== exp_w[i]) begin
                miss_n++;
                $display("FAIL short_word%0d: got @%h %h want @%h %h", i, wr_addr[3][i],
                         wr_data[3][i], 13'(i), exp_w[i]);
            end
        end
        vec_n++;
        if (busy_v[3] !== 1'b0 || wc_v[3] !== 13'd5 || done_n[3] !== 1) begin
            miss_n++;
            $display("FAIL short_idle: got busy=%b wc=%0d done=%0d want 0 5 1",
                     busy_v[3], wc_v[3], done_n[3]);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon(2);
        build_exp(16, 4, 2, 6, 20);
        cont_v[2] = 1'b1;
        tick(2);
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            if (f == 2) cont_v[2] = 1'b0;
            for (int y = 0; y < 6; y++) send_line(y, 20);
            tick(5);
        end
        vec_n++;
        if (done_n[2] !== 3 || wr_n[2] !== 18) begin
            miss_n++;
            $display("FAIL cont_count: got done=%0d writes=%0d want 3 18", done_n[2], wr_n[2]);
        end
        for (int i = 0; i < 18; i++) begin
            vec_n++;
            if (wr_addr[2][i] !== 13'(13'h100 + i % 6) || wr_data[2][i] !== exp_w[i % 6]) begin
                miss_n++;
                $display("FAIL cont_word%0d: got @%h %h want @%h %h", i, wr_addr[2][i],
                         wr_data[2][i], 13'(13'h100 + i % 6), exp_w[i % 6]);
            end
        end
        vec_n++;
        if (busy_v[2] !== 1'b0 || wc_v[2] !== 13'd6) begin
            miss_n++;
            $display("FAIL cont_end: got busy=%b wc=%0d want 0 6", busy_v[2], wc_v[2]);
        end
    endtask

    task automatic test_reset_mid();
        int wn0;
        bit seen;
        clear_mon(2);
        wn0 = 0;
        seen = 1'b0;
        arm_v[2] = 1'b1;
        tick(1);
        arm_v[2] = 1'b0;
        vsync_pulse();
        fork
            begin
                for (int y = 0; y < 6; y++) send_line(y, 20);
            end
            begin
                for (int i = 0; i < 3000 && !seen; i++) begin
                    tick(1);
                    if (wr_n[2] >= 1) seen = 1'b1;
                end
                vec_n++;
                if (!seen) begin
                    miss_n++;
                    $display("FAIL rstmid_wait: no write within 3000 cycles, want one");
                end
                rst_v[2] = 1'b1;
                tick(1);
                rst_v[2] = 1'b0;
                vec_n++;
                if (wea_v[2] !== 1'b0 || addra_v[2] !== 13'h100 || dina_v[2] !== 32'h0 ||
                    busy_v[2] !== 1'b0 || fd_v[2] !== 1'b0 || fs_v[2] !== 1'b0 ||
                    wc_v[2] !== 13'h0) begin
                    miss_n++;
                    $display("FAIL rstmid_out: wea=%b addra=%h dina=%h busy=%b fd=%b fs=%b wc=%h, want 0/100/0/0/0/0/0",
                             wea_v[2], addra_v[2], dina_v[2], busy_v[2], fd_v[2], fs_v[2],
                             wc_v[2]);
                end
                wn0 = wr_n[2];
            end
        join
        tick(10);
        vec_n++;
        if (wr_n[2] !== wn0 || done_n[2] !== 0) begin
            miss_n++;
            $display("FAIL rstmid_quiet: got writes=%0d done=%0d want %0d 0",
                     wr_n[2], done_n[2], wn0);
        end
        arm_v[2] = 1'b1;
        tick(1);
        arm_v[2] = 1'b0;
        send_frame(6, 20);
        vec_n++;
        if (wr_n[2] - wn0 !== 6 || wc_v[2] !== 13'd6) begin
            miss_n++;
            $display("FAIL rstmid_rearm: got writes=%0d wc=%0d want 6 6", wr_n[2] - wn0, wc_v[2]);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1;
            arm_v[k] = 1'b0;
            cont_v[k] = 1'b0;
            wr_n[k] = 0;
            done_n[k] = 0;
            short_n[k] = 0;
        end
        test_reset();
        test_pack_exact();
        test_pack_flush();
        test_decimate();
        test_short_frame();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
